// File: rtl/wide_add_sequencer_if.sv
// Request/response bundle between the issuing logic and wide_add_sequencer.
// With OVERFLOW_FLAG_EN defined, the bundle also carries the signed overflow flag ovf.
interface wide_add_sequencer_if #(
  parameter int unsigned WORDS = 4
);
  localparam int unsigned W = 32 * WORDS;

  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
`ifdef OVERFLOW_FLAG_EN
  logic         ovf;

  modport master (output start, sub, a, b, input busy, done, result, cout, ovf);
  modport slave  (input start, sub, a, b, output busy, done, result, cout, ovf);
`else
  modport master (output start, sub, a, b, input busy, done, result, cout);
  modport slave  (input start, sub, a, b, output busy, done, result, cout);
`endif
endinterface

// File: rtl/wide_add_sequencer.sv
// Multi-cycle WORDS x 32-bit add/subtract, one word per cycle, LSW first, sharing a single
// 32-bit ripple adder with the carry chained through a register.
// Optional feature: define OVERFLOW_FLAG_EN to add the signed overflow output ovf.
module wide_add_sequencer #(
  parameter int unsigned WORDS = 4
) (
  input logic              clk,
  input logic              rst,
  wide_add_sequencer_if.slave bus
);
  localparam int unsigned W = 32 * WORDS;
  localparam int unsigned IdxW = $clog2(WORDS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q;
  logic            carry_q;
  logic            sub_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    result_q;
  logic            cout_q;

  logic [IdxW+4:0] word_sel;
  logic [31:0]     x;
  logic [31:0]     y;
  logic [32:0]     sum;
  logic            last_word;
  logic            busy;
  logic            done;

`ifdef OVERFLOW_FLAG_EN
  logic            ovf_q;
`endif

  // Shared 32-bit adder on the current word; B is inverted for subtraction.
  always_comb begin
    word_sel  = {idx_q, 5'd0};
    x         = a_q[word_sel +: 32];
    y         = b_q[word_sel +: 32] ^ {32{sub_q}};
    sum       = {1'b0, x} + {1'b0, y} + {32'd0, carry_q};
    last_word = (idx_q == LastIdx);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only honoured in idle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StRun;
      StRun:   if (last_word) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs decoded from registered state only.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      StRun:   busy = 1'b1;
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  // Operand capture and in-place word-by-word result accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q    <= '0;
      carry_q  <= 1'b0;
      sub_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            sub_q   <= bus.sub;
            idx_q   <= '0;
            carry_q <= bus.sub;  // +1 of the two's-complement negate
          end
        end
        StRun: begin
          result_q[word_sel +: 32] <= sum[31:0];
          carry_q                  <= sum[32];
          idx_q                    <= idx_q + 1'b1;
          if (last_word) begin
            cout_q <= sum[32];
`ifdef OVERFLOW_FLAG_EN
            ovf_q  <= (x[31] == y[31]) && (sum[31] != x[31]);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = busy;
  assign bus.done   = done;
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
`ifdef OVERFLOW_FLAG_EN
  assign bus.ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench for wide_add_sequencer with WORDS = 4 (128-bit operands).
module tb_wide_add_sequencer;
  localparam int unsigned WORDS = 4;

  typedef struct {
    string        name;
    logic [127:0] a;
    logic [127:0] b;
    logic         sub;
    logic [127:0] exp_res;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  wide_add_sequencer_if #(.WORDS(WORDS)) bus ();

  wide_add_sequencer #(.WORDS(WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation from idle; returns result, flags and observed timing.
  task automatic do_op(input logic [127:0] a, input logic [127:0] b, input logic sub,
                       output logic [127:0] res, output logic cout, output logic ovf,
                       output int busy_cnt, output int lat, output logic extra_done);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.sub   = sub;
    step();
    bus.start = 1'b0;
    busy_cnt  = 0;
    lat       = 0;
    while (bus.done !== 1'b1 && lat < 20) begin
      if (bus.busy === 1'b1) busy_cnt++;
      step();
      lat++;
    end
    res  = bus.result;
    cout = bus.cout;
`ifdef OVERFLOW_FLAG_EN
    ovf  = bus.ovf;
`else
    ovf  = 1'b0;
`endif
    step();
    extra_done = bus.done;
  endtask

  function automatic void model(input logic [127:0] a, input logic [127:0] b, input logic sub,
                                output logic [127:0] res, output logic cout, output logic ovf);
    logic [127:0] yeff;
    logic [128:0] full;
    yeff = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, yeff} + {128'd0, sub};
    res  = full[127:0];
    cout = full[128];
    ovf  = (a[127] == yeff[127]) && (res[127] != a[127]);
  endfunction

  initial begin
    vec_t         vecs [7];
    logic [127:0] ones;
    logic [127:0] res;
    logic [127:0] exp_res;
    logic         cout;
    logic         exp_cout;
    logic         ovf;
    logic         exp_ovf;
    logic         extra;
    int           busy_cnt;
    int           lat;
    int           pulses;

    total = 0;
    bad   = 0;
    ones  = '1;

    vecs[0] = '{"add_1_0", 128'd1, 128'd0, 1'b0, 128'd1, 1'b0, 1'b0};
    vecs[1] = '{"ripple", 128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'd1, 1'b0,
                128'h00000001_00000000_00000000_00000000, 1'b0, 1'b0};
    vecs[2] = '{"wrap", ones, 128'd1, 1'b0, 128'd0, 1'b1, 1'b0};
    vecs[3] = '{"sub_5_3", 128'd5, 128'd3, 1'b1, 128'd2, 1'b1, 1'b0};
    vecs[4] = '{"sub_0_1", 128'd0, 128'd1, 1'b1, ones, 1'b0, 1'b0};
    vecs[5] = '{"sovf_add", 128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'd1, 1'b0,
                128'h80000000_00000000_00000000_00000000, 1'b0, 1'b1};
    vecs[6] = '{"sovf_sub", 128'h80000000_00000000_00000000_00000000, 128'd1, 1'b1,
                128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 1'b1, 1'b1};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    step();
    step();
    rst = 1'b0;
    chk("rst_busy", {127'd0, bus.busy}, 128'd0);
    chk("rst_done", {127'd0, bus.done}, 128'd0);
    chk("rst_result", bus.result, 128'd0);
    chk("rst_cout", {127'd0, bus.cout}, 128'd0);

    // Directed table.
    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].sub, res, cout, ovf, busy_cnt, lat, extra);
      chk({vecs[i].name, "_busy_cycles"}, 128'(busy_cnt), 128'd4);
      chk({vecs[i].name, "_done_latency"}, 128'(lat), 128'd4);
      chk({vecs[i].name, "_done_width"}, {127'd0, extra}, 128'd0);
      chk({vecs[i].name, "_result"}, res, vecs[i].exp_res);
      chk({vecs[i].name, "_cout"}, {127'd0, cout}, {127'd0, vecs[i].exp_cout});
`ifdef OVERFLOW_FLAG_EN
      chk({vecs[i].name, "_ovf"}, {127'd0, ovf}, {127'd0, vecs[i].exp_ovf});
`endif
    end

    // start held high through RUN and DONE with different operands is ignored.
    bus.start = 1'b1;
    bus.a     = 128'd10;
    bus.b     = 128'd20;
    bus.sub   = 1'b0;
    step();
    bus.a  = 128'd99;
    bus.b  = 128'd1;
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      if (bus.done === 1'b1) begin
        pulses++;
        chk("ign_result", bus.result, 128'd30);
      end
      if (c < 4) step();
    end
    bus.start = 1'b0;
    chk("ign_pulses", 128'(pulses), 128'd1);
    step();
    chk("ign_after_done", {127'd0, bus.done}, 128'd0);
    do_op(128'd99, 128'd1, 1'b0, res, cout, ovf, busy_cnt, lat, extra);
    chk("ign_next_result", res, 128'd100);

    // Reset on the second RUN word aborts without a done pulse.
    bus.start = 1'b1;
    bus.a     = ones;
    bus.b     = 128'd1;
    bus.sub   = 1'b0;
    step();
    bus.start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", {127'd0, bus.busy}, 128'd0);
    chk("abort_done", {127'd0, bus.done}, 128'd0);
    chk("abort_result", bus.result, 128'd0);
    chk("abort_cout", {127'd0, bus.cout}, 128'd0);
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.done === 1'b1) pulses++;
      step();
    end
    chk("abort_no_done", 128'(pulses), 128'd0);
    do_op(128'd7, 128'd8, 1'b0, res, cout, ovf, busy_cnt, lat, extra);
    chk("abort_restart", res, 128'd15);

    // Back-to-back random stream against a full-width reference.
    for (int i = 0; i < 20; i++) begin
      logic [127:0] ra;
      logic [127:0] rb;
      logic         rs;
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      rs = i[0];
      model(ra, rb, rs, exp_res, exp_cout, exp_ovf);
      do_op(ra, rb, rs, res, cout, ovf, busy_cnt, lat, extra);
      chk($sformatf("rand%0d_result", i), res, exp_res);
      chk($sformatf("rand%0d_cout", i), {127'd0, cout}, {127'd0, exp_cout});
`ifdef OVERFLOW_FLAG_EN
      chk($sformatf("rand%0d_ovf", i), {127'd0, ovf}, {127'd0, exp_ovf});
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
